// File: rtl/eduphics_pcie_mem_initiator.sv
// Single-outstanding PCIe-side initiator for the GPU memory port, with a watchdog abort on a silent responder.
// Latency: request rises 1 cycle after accept; rsp_valid rises 1 cycle after ready, or after TIMEOUT_CYCLES request cycles.
// Backpressure: cmd_ready is high only in IDLE; rsp_* hold until rsp_ready, so the next command waits for the handshake.
module eduphics_pcie_mem_initiator #(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [MEM_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic                      rsp_error,
    output logic [MEM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      pcie_read_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_read_addr,
    input  logic                      pcie_read_ready,
    input  logic [MEM_DATA_WIDTH-1:0] pcie_read_data,
    output logic                      pcie_write_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] pcie_write_data,
    input  logic                      pcie_write_ready,
    output logic                      busy
);

    // A zero timeout disables the watchdog, but the counter still needs at least one bit.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   tmo_cnt;
    logic            cmd_fire;
    logic            rd_done;
    logic            wr_done;
    logic            tmo_hit;
    logic            in_req;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rd_done  = (state == RD_REQ) && pcie_read_ready;
    assign wr_done  = (state == WR_REQ) && pcie_write_ready;
    assign in_req   = (state == RD_REQ) || (state == WR_REQ);
    // The count after this cycle's increment would equal TIMEOUT_CYCLES.
    assign tmo_hit  = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                if (pcie_read_ready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            WR_REQ: begin
                if (pcie_write_ready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so nothing combinational reaches a port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready          <= 1'b0;
            busy               <= 1'b0;
            pcie_read_request  <= 1'b0;
            pcie_write_request <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_write          <= 1'b0;
            rsp_error          <= 1'b0;
            rsp_rdata          <= '0;
            pcie_read_addr     <= '0;
            pcie_write_addr    <= '0;
            pcie_write_data    <= '0;
            tmo_cnt            <= '0;
        end else begin
            cmd_ready          <= (state_nxt == IDLE);
            busy               <= (state_nxt != IDLE);
            pcie_read_request  <= (state_nxt == RD_REQ);
            pcie_write_request <= (state_nxt == WR_REQ);
            rsp_valid          <= (state_nxt == RESP);

            if (cmd_fire) begin
                pcie_read_addr  <= cmd_addr;
                pcie_write_addr <= cmd_addr;
                pcie_write_data <= cmd_wdata;
            end

            if (in_req) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            // Response fields load once on leaving a request state and then hold through RESP.
            if (in_req && (state_nxt == RESP)) begin
                rsp_write <= (state == WR_REQ);
                rsp_error <= !(rd_done || wr_done);
                rsp_rdata <= rd_done ? pcie_read_data : '0;
            end
        end
    end

endmodule
